// File: rtl/reg_share_arbiter.sv
// Shares one WIDTH-bit register among N_REQ requesters: round-robin arbitration, one-cycle
// grant pulse, then HOLD_CYCLES busy cycles. Define ARB_FIXED_PRIO_EN for fixed lowest-index priority.
module reg_share_arbiter #(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned ID_W        = 2,
  parameter int unsigned HOLD_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*WIDTH-1:0]   data_in,
  output logic [N_REQ-1:0]         gnt,
  output logic [WIDTH-1:0]         q,
  output logic                     q_valid,
  output logic [ID_W-1:0]          owner,
  output logic                     busy
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  state_e             state_q;
  logic [ID_W-1:0]    ptr_q;
  logic [CNT_W-1:0]   hold_cnt_q;
  logic [N_REQ-1:0]   gnt_q;
  logic [WIDTH-1:0]   q_q;
  logic               q_valid_q;
  logic [ID_W-1:0]    owner_q;
  logic               busy_q;

  logic               win_vld_d;
  logic [ID_W-1:0]    win_idx_d;
  logic [ID_W-1:0]    ptr_d;
  logic [WIDTH-1:0]   slice_d;
  logic [N_REQ-1:0]   rot_d;
  int unsigned        idx_d;

  // Winner search: first asserted request starting at ptr_q, wrapping modulo N_REQ.
  // In the fixed-priority build ptr_q is pinned to zero, so the search always starts at 0.
  always_comb begin
    win_vld_d = 1'b0;
    win_idx_d = '0;
    rot_d     = '0;
    idx_d     = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx_d = 32'(ptr_q) + k;
      if (idx_d >= N_REQ) begin
        idx_d = idx_d - N_REQ;
      end
      rot_d = req >> idx_d;
      if (!win_vld_d && rot_d[0]) begin
        win_vld_d = 1'b1;
        win_idx_d = ID_W'(idx_d);
      end
    end
  end

  always_comb begin
    slice_d = WIDTH'(data_in >> (32'(win_idx_d) * WIDTH));
`ifdef ARB_FIXED_PRIO_EN
    ptr_d = '0;
`else
    if (win_idx_d == ID_W'(N_REQ - 1)) begin
      ptr_d = '0;
    end else begin
      ptr_d = win_idx_d + ID_W'(1);
    end
`endif
  end

  // Arbitration FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      hold_cnt_q <= '0;
      gnt_q      <= '0;
      q_q        <= '0;
      q_valid_q  <= 1'b0;
      owner_q    <= '0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          gnt_q <= '0;
          if (win_vld_d) begin
            q_q        <= slice_d;
            gnt_q      <= N_REQ'(1) << win_idx_d;
            owner_q    <= win_idx_d;
            q_valid_q  <= 1'b1;
            ptr_q      <= ptr_d;
            busy_q     <= 1'b1;
            hold_cnt_q <= CNT_W'(HOLD_CYCLES);
            state_q    <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          gnt_q <= '0;
          if (hold_cnt_q == '0) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            hold_cnt_q <= hold_cnt_q - CNT_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign gnt     = gnt_q;
  assign q       = q_q;
  assign q_valid = q_valid_q;
  assign owner   = owner_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_reg_share_arbiter.sv
// Scoreboard bench for reg_share_arbiter: a cycle-arithmetic reference model predicts grants
// and per-cycle status; a monitor on the falling edge pops and compares.
module tb_reg_share_arbiter;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned ID_W  = 2;
  localparam int unsigned HOLD  = 2;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] data_in;
  logic [N_REQ-1:0]       gnt;
  logic [WIDTH-1:0]       q;
  logic                   q_valid;
  logic [ID_W-1:0]        owner;
  logic                   busy;

  reg_share_arbiter #(
    .N_REQ(N_REQ), .WIDTH(WIDTH), .ID_W(ID_W), .HOLD_CYCLES(HOLD)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .data_in(data_in),
    .gnt(gnt), .q(q), .q_valid(q_valid), .owner(owner), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N_REQ-1:0] gnt;
    logic [WIDTH-1:0] q;
    logic             qv;
    logic [ID_W-1:0]  owner;
    logic             busy;
  } stat_t;

  typedef struct {
    logic [N_REQ-1:0] gnt;
    logic [WIDTH-1:0] q;
    logic [ID_W-1:0]  owner;
  } grant_t;

  stat_t  stat_q[$];
  grant_t grant_q[$];

  int tests = 0;
  int fails = 0;

  // Reference model state: edge index, last grant edge, rotating start position.
  int     m_edge   = 0;
  int     m_last   = 0;
  bit     m_active = 1'b0;
  int     m_ptr    = 0;
  stat_t  m_stat;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Predicts what the next rising edge does with the inputs being applied now.
  task automatic model_edge(input logic rst, input logic [N_REQ-1:0] r, input logic [N_REQ*WIDTH-1:0] d);
    int     start;
    int     w;
    bit     free;
    grant_t g;
    logic [N_REQ-1:0] sh;
    if (rst) begin
      m_active     = 1'b0;
      m_ptr        = 0;
      m_stat.gnt   = '0;
      m_stat.q     = '0;
      m_stat.qv    = 1'b0;
      m_stat.owner = '0;
      m_stat.busy  = 1'b0;
    end else begin
      m_stat.gnt = '0;
      free = !m_active || (m_edge >= m_last + int'(HOLD) + 2);
      w = -1;
`ifdef ARB_FIXED_PRIO_EN
      start = 0;
`else
      start = m_ptr;
`endif
      if (free) begin
        for (int k = 0; k < int'(N_REQ); k++) begin
          sh = r >> ((start + k) % int'(N_REQ));
          if (w < 0 && sh[0]) w = (start + k) % int'(N_REQ);
        end
      end
      if (w >= 0) begin
        m_stat.gnt   = N_REQ'(1) << w;
        m_stat.q     = WIDTH'(d >> (w * int'(WIDTH)));
        m_stat.qv    = 1'b1;
        m_stat.owner = ID_W'(w);
        m_stat.busy  = 1'b1;
        m_active     = 1'b1;
        m_last       = m_edge;
`ifndef ARB_FIXED_PRIO_EN
        m_ptr        = (w + 1) % int'(N_REQ);
`endif
        g.gnt = m_stat.gnt; g.q = m_stat.q; g.owner = m_stat.owner;
        grant_q.push_back(g);
      end else begin
        m_stat.busy = m_active && (m_edge <= m_last + int'(HOLD));
      end
    end
    stat_q.push_back(m_stat);
    m_edge++;
  endtask

  task automatic step(input logic rst, input logic [N_REQ-1:0] r, input logic [N_REQ*WIDTH-1:0] d);
    reset   = rst;
    req     = r;
    data_in = d;
    model_edge(rst, r, d);
    @(posedge clk);
    #1;
  endtask

  // Monitor: per-cycle status compare, plus grant scoreboard popped when the DUT grants.
  initial begin
    stat_t  s;
    grant_t g;
    forever begin
      @(negedge clk);
      if (stat_q.size() > 0) begin
        s = stat_q.pop_front();
        check("gnt",     32'(gnt),     32'(s.gnt));
        check("q",       32'(q),       32'(s.q));
        check("q_valid", 32'(q_valid), 32'(s.qv));
        check("owner",   32'(owner),   32'(s.owner));
        check("busy",    32'(busy),    32'(s.busy));
      end
      if (gnt !== '0 && !$isunknown(gnt)) begin
        if (grant_q.size() == 0) begin
          check("unexpected_grant", 32'(gnt), 32'(0));
        end else begin
          g = grant_q.pop_front();
          check("grant_gnt",   32'(gnt),   32'(g.gnt));
          check("grant_q",     32'(q),     32'(g.q));
          check("grant_owner", 32'(owner), 32'(g.owner));
        end
      end
    end
  end

  initial begin
    logic [N_REQ-1:0]       r;
    logic [N_REQ*WIDTH-1:0] d;
    // Reset with all requests asserted
    step(1'b1, 4'b1111, 32'h13121110);
    step(1'b1, 4'b1111, 32'h13121110);
    // Single request from requester 2
    step(1'b0, 4'b0100, 32'h00A50000);
    for (int i = 0; i < 6; i++) step(1'b0, 4'b0000, 32'($urandom));
    // Round-robin across all requesters
    for (int i = 0; i < 22; i++) step(1'b0, 4'b1111, 32'h13121110);
    // Wrap-around: grant 2 first, then 0 and 1
    step(1'b1, 4'b0000, 32'h0);
    step(1'b0, 4'b0100, 32'h00220000);
    for (int i = 0; i < 3; i++) step(1'b0, 4'b0000, 32'h0);
    for (int i = 0; i < 10; i++) step(1'b0, 4'b0011, 32'h00003C5A);
    // Reset in the middle of a hold
    step(1'b1, 4'b0000, 32'h0);
    step(1'b0, 4'b0010, 32'h00007700);
    step(1'b0, 4'b0000, 32'h0);
    step(1'b1, 4'b0000, 32'h0);
    for (int i = 0; i < 6; i++) step(1'b0, 4'b1010, 32'h44332211);
    // Fixed-pattern upper-half requests
    for (int i = 0; i < 10; i++) step(1'b0, 4'b1100, 32'($urandom));
    // Randomized traffic with sparse resets
    for (int i = 0; i < 1500; i++) begin
      r = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
      d = 32'($urandom);
      step(($urandom_range(0, 59) == 0), r, d);
    end
    step(1'b0, 4'b0000, 32'h0);
    @(negedge clk);
    @(negedge clk);
    check("stat_queue_drained",  32'(stat_q.size()),  32'(0));
    check("grant_queue_drained", 32'(grant_q.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/reg_share_arbiter.md
Name: reg_share_arbiter

Overview:
- Shares one WIDTH-bit D-type storage register among N_REQ requesters.
- Selects one pending requester per arbitration slot (round-robin by default), loads its data into the shared register and pulses its grant.
- Then holds the resource busy for HOLD_CYCLES cycles before the next slot.
- Sits between requesting blocks and the shared flip-flop bank; the shared register is internal and its value is exported on q.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WIDTH, 8, data / shared register width.
- ID_W, 2, width of owner index; must satisfy 2**ID_W >= N_REQ.
- HOLD_CYCLES, 2, busy cycles after each grant cycle (0..15).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- req  in  N_REQ  per-requester write request, level.
- data_in  in  N_REQ*WIDTH  requester i data in bits [i*WIDTH +: WIDTH].
- gnt  out  N_REQ  one-hot grant pulse, registered.
- q  out  WIDTH  shared register contents.
- q_valid  out  1  shared register written at least once since reset.
- owner  out  ID_W  index of last granted requester.
- busy  out  1  resource occupied (no arbitration this cycle).

Behaviour:
- Single clock domain; all state and outputs are updated on the posedge of clk; all outputs are registered.
- Reset is sampled at posedge and overrides all other inputs:
  - state=IDLE, ptr=0, hold_cnt=0.
  - gnt=0, q=0, q_valid=0, owner=0, busy=0.
  - Reset asserted mid-HOLD aborts the hold immediately; the next cycle shows reset values.
- States: IDLE, HOLD.
- IDLE, req==0: remain in IDLE; all outputs hold, except gnt=0.
- IDLE, req!=0 at an edge: winner i = first set bit of req searching ptr, ptr+1, ... modulo N_REQ (wraps N_REQ-1 -> 0). At that same edge:
  - q <= data_in slice i.
  - gnt <= one-hot(i).
  - owner <= i; q_valid <= 1.
  - ptr <= (i+1) mod N_REQ.
  - busy <= 1; hold_cnt <= HOLD_CYCLES; state <= HOLD.
- Latency: req sampled at edge E; gnt and the new q are visible in the cycle after E.
- HOLD:
  - gnt returns to 0 at the next edge, so it is exactly one cycle wide.
  - req is ignored.
  - If hold_cnt==0: state <= IDLE, busy <= 0. Otherwise hold_cnt decrements.
- Timing consequence: busy is high for HOLD_CYCLES+1 cycles per grant, and grants are spaced at least HOLD_CYCLES+2 cycles apart.
- Requester protocol:
  - Hold req until gnt is seen.
  - Deassert req in the gnt cycle, otherwise the request is treated as a new one and rearbitrated after the others.
  - Dropping req before grant withdraws it with no side effect.
- Only the sampled data slice matters; data_in is don't-care outside the granting edge.
- q and owner hold their values between grants.
- q_valid stays 1 until reset.

Optional Feature:
- Macro ARB_FIXED_PRIO_EN.
- Defined: fixed priority. The lowest-index asserted req always wins; ptr is neither used nor updated (it stays 0).
- Undefined: the round-robin behaviour above.
- All other timing is identical in both builds.

Test Plan:
- Reset: reset=1 for 2 cycles with req=4'b1111 -> gnt=0, q=8'h00, q_valid=0, owner=0, busy=0 throughout; first grant appears 1 cycle after reset release.
- Single request: req=4'b0100, slice2=8'hA5 -> next cycle gnt=4'b0100 for 1 cycle, q=8'hA5, owner=2, q_valid=1; busy high exactly 3 cycles; q stays 8'hA5 afterwards.
- Round-robin: req=4'b1111 held, slice i=8'h10+i -> gnt sequence 0001, 0010, 0100, 1000, 0001, each 4 cycles apart; q goes 10, 11, 12, 13, 10; owner goes 0, 1, 2, 3, 0.
- Wrap-around: grant requester 2 first (ptr=3), then req=4'b0011 -> gnt=0001, then gnt=0010 4 cycles later.
- Reset mid-hold: grant requester 1, assert reset in the 2nd busy cycle -> next cycle busy=0, q=0, q_valid=0, owner=0; after release, req=4'b1010 -> gnt=0010 (ptr reset to 0).
- ARB_FIXED_PRIO_EN defined: req=4'b1111 held -> gnt=0001 on every slot, 4 cycles apart; req=4'b1100 -> gnt=0100 on every slot.
